// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter: data port has fixed priority over instruction fetch.
// Strobes, ready pulses and read data are all registered.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic [19:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, ACC, WREC} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic       owner_mem;
  logic       is_write;
  logic       if_elig, mem_elig;
  logic       grant, grant_mem;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[31:22], if_addr[1:0], mem_addr[31:22], mem_addr[1:0]};
  assign stall = (if_req & ~if_ready) | (mem_req & ~mem_ready);

  // A port pulsing ready this cycle is ineligible, so a held request is not re-serviced.
  always_comb begin
    if_elig   = if_req & ~if_ready;
    mem_elig  = mem_req & ~mem_ready;
    grant     = 1'b0;
    grant_mem = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_elig) begin
          grant     = 1'b1;
          grant_mem = 1'b1;
          state_nxt = ACC;
        end else if (if_elig) begin
          grant     = 1'b1;
          state_nxt = ACC;
        end
      end
      ACC:     if (cnt == '0) state_nxt = is_write ? WREC : IDLE;
      WREC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      owner_mem  <= 1'b0;
      is_write   <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner_mem <= grant_mem;
            is_write  <= grant_mem & mem_we;
            sram_addr <= grant_mem ? mem_addr[21:2] : if_addr[21:2];
            if (grant_mem & mem_we) sram_wdata <= mem_wdata;
            cnt       <= 3'(WAIT_CYCLES);
            sram_ce_n <= 1'b0;
            sram_oe_n <= grant_mem & mem_we;
            sram_we_n <= ~(grant_mem & mem_we);
          end
        end
        ACC: begin
          if (cnt != '0) begin
            cnt <= cnt - 3'd1;
          end else if (is_write) begin
            sram_we_n <= 1'b1;
          end else begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (owner_mem) begin
              mem_rdata <= sram_rdata;
              mem_ready <= 1'b1;
            end else begin
              if_rdata <= sram_rdata;
              if_ready <= 1'b1;
            end
          end
        end
        WREC: begin
          sram_ce_n <= 1'b1;
          mem_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected responses, a monitor
// pops and compares them whenever a ready pulse appears.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, sram_wdata, sram_rdata;
  logic        if_ready, mem_ready, sram_ce_n, sram_oe_n, sram_we_n, stall;
  logic [19:0] sram_addr;

  logic        if_req_z;
  logic [31:0] if_addr_z, if_rdata_z, mem_rdata_z, sram_wdata_z, sram_rdata_z;
  logic        if_ready_z, mem_ready_z, ce_n_z, oe_n_z, we_n_z, stall_z;
  logic [19:0] sram_addr_z;

  mem_arbiter #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .stall(stall)
  );

  mem_arbiter #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(reset),
    .if_req(if_req_z), .if_addr(if_addr_z), .if_rdata(if_rdata_z), .if_ready(if_ready_z),
    .mem_req(1'b0), .mem_we(1'b0), .mem_addr(32'h0), .mem_wdata(32'h0),
    .mem_rdata(mem_rdata_z), .mem_ready(mem_ready_z),
    .sram_addr(sram_addr_z), .sram_wdata(sram_wdata_z), .sram_rdata(sram_rdata_z),
    .sram_ce_n(ce_n_z), .sram_oe_n(oe_n_z), .sram_we_n(we_n_z), .stall(stall_z)
  );

  // SRAM model: 256 words, writes land while ce_n and we_n are both low.
  logic [31:0] sram_mem [256];
  always @(posedge clk) begin
    if (reset) begin
      sram_mem[4] <= 32'hDEADBEEF;
      sram_mem[8] <= 32'hCAFEF00D;
    end else if (!sram_ce_n && !sram_we_n) begin
      sram_mem[sram_addr[7:0]] <= sram_wdata;
    end
  end
  assign sram_rdata   = sram_mem[sram_addr[7:0]];
  assign sram_rdata_z = {12'hA5A, sram_addr_z};

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int cyc; } exp_t;
  exp_t q_if[$];
  exp_t q_mem[$];
  exp_t q_z[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic prev_ready_z = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    check("ready_excl", {31'b0, if_ready & mem_ready}, 32'd0);
    check("strobe_legal", {31'b0, ~sram_oe_n & ~sram_we_n}, 32'd0);
    check("stall_formula", {31'b0, stall}, {31'b0, (if_req & ~if_ready) | (mem_req & ~mem_ready)});
    if (if_ready) begin
      if (q_if.size() == 0) check("if_ready_unexpected", 32'd1, 32'd0);
      else begin
        e = q_if.pop_front();
        check("if_rdata", if_rdata, e.data);
        check("if_ready_cycle", cyc, e.cyc);
      end
    end
    if (mem_ready) begin
      if (q_mem.size() == 0) check("mem_ready_unexpected", 32'd1, 32'd0);
      else begin
        e = q_mem.pop_front();
        check("mem_rdata", mem_rdata, e.data);
        check("mem_ready_cycle", cyc, e.cyc);
      end
    end
    if (if_ready_z) begin
      check("w0_no_consecutive", {31'b0, prev_ready_z}, 32'd0);
      if (q_z.size() == 0) check("w0_ready_unexpected", 32'd1, 32'd0);
      else begin
        e = q_z.pop_front();
        check("w0_if_rdata", if_rdata_z, e.data);
        check("w0_ready_cycle", cyc, e.cyc);
      end
    end
    prev_ready_z = if_ready_z;
  end

  task automatic wait_ready(input bit port_mem);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (port_mem ? mem_ready : if_ready) return;
    end
    check(port_mem ? "mem_ready_timeout" : "if_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int lat);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    q_if.push_back('{data, cyc + lat});
    wait_ready(1'b0);
    @(negedge clk);
    if_req = 1'b0;
  endtask

  task automatic mem_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp, input int lat);
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    q_mem.push_back('{exp, cyc + lat});
    wait_ready(1'b1);
    @(negedge clk);
    mem_req = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    if_req_z = 1'b0; if_addr_z = '0;
    repeat (3) @(negedge clk);

    check("rst_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    check("rst_readies", {30'b0, if_ready, mem_ready}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_sram_addr", {12'b0, sram_addr}, 32'd0);
    check("rst_sram_wdata", sram_wdata, 32'd0);

    // Fetch issued in the very cycle reset drops.
    reset = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0010;
    q_if.push_back('{32'hDEADBEEF, cyc + 3});
    step();
    check("f_sram_addr", {12'b0, sram_addr}, 32'h4);
    check("f_strobes_acc1", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'b001);
    step();
    check("f_strobes_acc2", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'b001);
    step();
    check("f_if_ready", {31'b0, if_ready}, 32'd1);
    check("f_strobes_idle", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'b111);
    @(negedge clk); if_req = 1'b0;

    // Write with one wait state, then WREC.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0100; mem_wdata = 32'h12345678;
    q_mem.push_back('{32'h0, cyc + 4});
    step();
    check("w_strobes_acc1", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'b010);
    check("w_sram_addr", {12'b0, sram_addr}, 32'h40);
    check("w_sram_wdata", sram_wdata, 32'h12345678);
    check("w_stall1", {31'b0, stall}, 32'd1);
    step();
    check("w_strobes_acc2", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'b010);
    check("w_stall2", {31'b0, stall}, 32'd1);
    step();
    check("w_strobes_wrec", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'b011);
    check("w_wrec_addr", {12'b0, sram_addr}, 32'h40);
    check("w_stall3", {31'b0, stall}, 32'd1);
    check("w_no_early_ready", {31'b0, mem_ready}, 32'd0);
    step();
    check("w_mem_ready", {31'b0, mem_ready}, 32'd1);
    check("w_stall_release", {31'b0, stall}, 32'd0);
    check("w_strobes_idle", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'b111);
    @(negedge clk); mem_req = 1'b0; mem_we = 1'b0;

    mem_access(1'b0, 32'h0000_0100, 32'h0, 32'h12345678, 3);

    // Simultaneous requests: data first, fetch granted in the mem_ready cycle.
    fork
      fetch(32'h0000_0020, 32'hCAFEF00D, 6);
      mem_access(1'b0, 32'h0000_0010, 32'h0, 32'hDEADBEEF, 3);
    join
    mem_access(1'b0, 32'h0000_0100, 32'h0, 32'h12345678, 3);
    check("if_rdata_held", if_rdata, 32'hCAFEF00D);

    // Request dropped early still completes with its ready pulse.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0010;
    q_if.push_back('{32'hDEADBEEF, cyc + 3});
    @(negedge clk); if_req = 1'b0;
    wait_ready(1'b0);

    // Reset during the second ACC cycle of a write aborts it.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0200; mem_wdata = 32'hAAAA5555;
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    reset = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    step();
    check("abort_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'b111);
    check("abort_no_ready", {30'b0, if_ready, mem_ready}, 32'd0);
    check("abort_sram_addr", {12'b0, sram_addr}, 32'd0);
    @(negedge clk); reset = 1'b0;
    step();
    check("abort_idle_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'b111);
    mem_access(1'b0, 32'h0000_0020, 32'h0, 32'hCAFEF00D, 3);

    // WAIT_CYCLES=0 with fetch held: a ready every third cycle.
    @(negedge clk);
    if_req_z = 1'b1; if_addr_z = 32'h0000_0040;
    for (int k = 0; k < 3; k++) q_z.push_back('{32'hA5A00010, cyc + 2 + 3 * k});
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(posedge clk); #2;
      if (if_ready_z) n++;
    end
    check("w0_ready_count", n, 32'd3);
    @(negedge clk); if_req_z = 1'b0;

    repeat (5) @(negedge clk);
    check("q_if_drained", q_if.size(), 32'd0);
    check("q_mem_drained", q_mem.size(), 32'd0);
    check("q_w0_drained", q_z.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra SRAM access cycles beyond the first; legal range 0..7.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 if_req  in  1  instruction-fetch read request; held high with if_addr stable until if_ready.
REQ-005 if_addr  in  32  fetch byte address; bits [1:0] ignored.
REQ-006 if_rdata  out  32  fetched word; valid while if_ready=1 and held until the next fetch completes.
REQ-007 if_ready  out  1  one-cycle completion pulse for the fetch port.
REQ-008 mem_req  in  1  data-port request; held high with mem_we, mem_addr, mem_wdata stable until mem_ready.
REQ-009 mem_we  in  1  1 = word write, 0 = word read.
REQ-010 mem_addr  in  32  data byte address; bits [1:0] ignored.
REQ-011 mem_wdata  in  32  write data.
REQ-012 mem_rdata  out  32  read word; valid while mem_ready=1 and held until the next data read completes.
REQ-013 mem_ready  out  1  one-cycle completion pulse for the data port.
REQ-014 sram_addr  out  20  SRAM word address, equal to granted address[21:2].
REQ-015 sram_wdata  out  32  SRAM write data.
REQ-016 sram_rdata  in  32  SRAM read data.
REQ-017 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes, all driven from registers.
REQ-018 stall  out  1  pipeline freeze, equal to (if_req & ~if_ready) | (mem_req & ~mem_ready), combinational.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, ACC and WREC.
REQ-020 In IDLE, eligible requests: if_req with if_ready=0 this cycle, and mem_req with mem_ready=0 this cycle.
REQ-021 Arbitration is fixed priority: the data port wins over the fetch port when both are eligible in the same cycle.
REQ-022 Grant edge: latch grant owner, sram_addr, sram_wdata, the write flag and wait counter = WAIT_CYCLES; move to ACC.
REQ-023 During ACC: sram_ce_n=0; read: oe_n=0, we_n=1; write: oe_n=1, we_n=0.
REQ-024 In ACC, the counter SHALL decrement on each clock edge while it is nonzero.
REQ-025 ACC with counter=0, read: capture sram_rdata into the owner's rdata register, pulse the owner's ready the next cycle, go to IDLE.
REQ-026 ACC with counter=0, write: go to WREC.
REQ-027 WREC lasts exactly one cycle: ce_n=0, we_n=1, oe_n=1, with address and data held; it then pulses mem_ready and goes to IDLE.
REQ-028 In IDLE, all three strobes SHALL be 1, and sram_addr and sram_wdata SHALL hold their last values.
REQ-029 Read latency from the first cycle the request is seen in IDLE to the ready cycle SHALL be WAIT_CYCLES+2.
REQ-030 Write latency from the first cycle the request is seen in IDLE to the ready cycle SHALL be WAIT_CYCLES+3.
REQ-031 A ready cycle is also an IDLE cycle, so the other port may be granted in it, which gives back-to-back accesses with no bubble.
REQ-032 The port pulsing ready is ineligible that cycle, so a held request is never serviced twice.
REQ-033 A request arriving while the FSM is in ACC or WREC waits; requests are never dropped.
REQ-034 Fetch starvation is permitted by design, because a data request is always followed by a stall release.
REQ-035 if_ready and mem_ready SHALL never be high in the same cycle.
REQ-036 At most one SRAM access SHALL be in flight at any time.
REQ-037 A request deasserted before its ready (protocol violation) SHALL NOT corrupt the FSM; the access completes and its ready pulse is still issued.

Reset
REQ-038 With reset=1 at a clock edge: state becomes IDLE, all strobes 1, counter 0, if_ready=mem_ready=0, if_rdata=mem_rdata=0, sram_addr=0, sram_wdata=0.
REQ-039 Reset asserted mid-ACC or mid-WREC SHALL abort the access with no ready pulse, and strobes SHALL be inactive from the next cycle.
REQ-040 The first grant is possible in the first cycle after reset deasserts.

Verification
REQ-041 WAIT_CYCLES=1; if_req with if_addr=0x0000_0010 and sram_rdata=0xDEADBEEF -> sram_addr=0x00004 and oe_n=0 for 2 cycles; if_ready with if_rdata=0xDEADBEEF 3 cycles after the request.
REQ-042 WAIT_CYCLES=1; write of mem_addr=0x0000_0100 with data 0x12345678 -> we_n=0 for 2 cycles, then WREC, then mem_ready 4 cycles after the request; stall high for the first 4 cycles.
REQ-043 if_req and mem_req (read) in the same cycle -> data access first; the fetch is granted in the mem_ready cycle; if_ready follows 3 cycles later.
REQ-044 WAIT_CYCLES=0 back-to-back fetches with if_req held -> if_ready every 3rd cycle, never on consecutive cycles.
REQ-045 reset during the second ACC cycle of a write -> no mem_ready; strobes at 1 the next cycle; a fresh read completes normally afterwards.
REQ-046 Check every cycle: ready exclusivity (REQ-035), strobe legality (oe_n and we_n never both 0), and stall equal to its formula.
